// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the fetch FSM state enum, the instruction width and the default PC parameters.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_out_reg.sv
// IF/ID output register: a valid/ready holding stage with a flush input.
// Ports: clk, rst_n, flush, load, ready, d_instr, d_pc -> valid, instr, pc.
module ifetch_out_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic               ready,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [31:0]        d_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc
);

    // Payload only changes on load, so a stalled entry is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control, zero-latency imem port.
// Ports: start/halt/redirect control in, imem_addr/imem_cmd, out_valid/out_ready handshake, status out.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_cmd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] fetch_count,
    output logic        misalign_err,
    output logic [1:0]  state_o
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc;
    logic         fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A redirect freezes the state; halt beats start.
    always_comb begin
        state_nx = state;
        fire     = 1'b0;
        if (!redirect_valid) begin
            unique case (state)
                ST_IDLE, ST_HALT: begin
                    if (start && !halt) begin
                        state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_nx = ST_HALT;
                    end else if (!out_valid || out_ready) begin
                        fire = 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (fire) begin
            pc <= pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

    // Counts every handshake, even one that is flushed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (out_valid && out_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    ifetch_out_reg u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .load    (fire),
        .ready   (out_ready),
        .d_instr (imem_cmd),
        .d_pc    (pc),
        .valid   (out_valid),
        .instr   (instr),
        .pc      (instr_pc)
    );

    assign imem_addr = pc;
    assign state_o   = state;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed vectors plus a transaction-level model.
// Every negedge the DUT outputs are compared against the model.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_cmd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] fetch_count;
    logic        misalign_err;
    logic [1:0]  state_o;

    int tests = 0;
    int fails = 0;

    ifetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_cmd       (imem_cmd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   mem = 32'h2010_0096;
            32'h4:   mem = 32'hAC10_00FF;
            32'h8:   mem = 32'h2011_00FF;
            32'hC:   mem = 32'hAC11_00FF;
            default: mem = {~a[15:0], a[15:0]};
        endcase
    endfunction

    always_comb imem_cmd = mem(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one pending fetched word, the PC to fetch next, mode and counters.
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_v, m_mis;
    int          m_mode;  // 0 idle, 1 run, 2 halt

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_v = 0; m_instr = 0; m_ipc = 0;
            m_cnt = 0; m_mis = 0; m_mode = 0;
        end else begin
            bit took, issue;
            took  = m_v && out_ready;
            issue = (m_mode == 1) && !redirect_valid && !halt
                    && (!m_v || out_ready);
            if (took) m_cnt = m_cnt + 1;
            if (redirect_valid) begin
                m_v = 0;
                if (redirect_pc % 4 != 0) m_mis = 1;
                m_pc = redirect_pc - (redirect_pc % 4);
            end else begin
                if (issue) begin
                    m_v = 1;
                    m_instr = mem(m_pc);
                    m_ipc = m_pc;
                    m_pc = m_pc + 4;
                end else if (took) begin
                    m_v = 0;
                end
                if (m_mode == 1 && halt) m_mode = 2;
                else if (m_mode != 1 && start && !halt) m_mode = 1;
            end
        end
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_v});
            if (m_v) begin
                chk("m_instr", instr, m_instr);
                chk("m_instr_pc", instr_pc, m_ipc);
            end
            chk("m_fetch_count", fetch_count, m_cnt);
            chk("m_misalign", {31'b0, misalign_err}, {31'b0, m_mis});
            chk("m_state", {30'b0, state_o}, m_mode[31:0]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 0;
        start = 0; halt = 0; redirect_valid = 0; out_ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, {30'b0, state_o}, 32'd0);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_ipc"}, instr_pc, 32'h0);
        chk({tag, "_cnt"}, fetch_count, 32'h0);
        chk({tag, "_mis"}, {31'b0, misalign_err}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("rst0");
        rst_n = 1;
        cmp_en = 1;

        // Streaming with out_ready high
        start = 1; out_ready = 1;
        cyc();
        chk("s_run", {30'b0, state_o}, 32'd1);
        chk("s_nv", {31'b0, out_valid}, 32'd0);
        start = 0;
        cyc(); chk("s_i0", instr, 32'h2010_0096); chk("s_p0", instr_pc, 32'h0);
        cyc(); chk("s_i1", instr, 32'hAC10_00FF); chk("s_p1", instr_pc, 32'h4);
        cyc(); chk("s_i2", instr, 32'h2011_00FF); chk("s_p2", instr_pc, 32'h8);
        cyc(); chk("s_i3", instr, 32'hAC11_00FF); chk("s_p3", instr_pc, 32'hC);
        halt = 1;
        cyc();
        chk("s_cnt", fetch_count, 32'd4);
        chk("s_halt", {30'b0, state_o}, 32'd2);
        halt = 0;

        // Back-pressure
        do_reset();
        start = 1; out_ready = 0;
        cyc(); start = 0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("bp_instr", instr, 32'h2010_0096);
            chk("bp_ipc", instr_pc, 32'h0);
            chk("bp_addr", imem_addr, 32'h4);
            if (i < 2) cyc();
        end
        out_ready = 1;
        cyc(); chk("bp_p1", instr_pc, 32'h4);
        cyc(); chk("bp_p2", instr_pc, 32'h8);

        // Redirect flushes a pending word
        do_reset();
        start = 1; out_ready = 1;
        cyc(); start = 0;
        cyc(); cyc();
        chk("rd_pend", instr_pc, 32'h4);
        out_ready = 0; redirect_valid = 1; redirect_pc = 32'h8;
        cyc();
        chk("rd_flush", {31'b0, out_valid}, 32'd0);
        redirect_valid = 0; out_ready = 1;
        cyc();
        chk("rd_instr", instr, 32'h2011_00FF);
        chk("rd_ipc", instr_pc, 32'h8);

        // Misaligned redirect
        redirect_valid = 1; redirect_pc = 32'h6;
        cyc();
        chk("mis_flag", {31'b0, misalign_err}, 32'd1);
        redirect_valid = 0;
        cyc();
        chk("mis_ipc", instr_pc, 32'h4);

        // Halt beats start
        halt = 1; start = 1;
        cyc();
        chk("hs_state", {30'b0, state_o}, 32'd2);
        halt = 0; start = 0;
        cyc();
        chk("hs_nv", {31'b0, out_valid}, 32'd0);
        chk("hs_addr", imem_addr, 32'h8);
        start = 1;
        cyc(); start = 0;
        cyc();
        chk("hs_resume", instr_pc, 32'h8);
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 200; i++) begin
            out_ready = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(9) == 0);
            redirect_pc = {26'b0, 6'($urandom_range(63))};
            halt = ($urandom_range(19) == 0);
            start = ($urandom_range(4) == 0);
            cyc();
        end
        out_ready = 1; halt = 0; start = 1; redirect_valid = 0;
        cyc(); start = 0;

        // PC wrap
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        cyc(); redirect_valid = 0;
        cyc(); chk("wr_p0", instr_pc, 32'hFFFF_FFFC);
        cyc(); chk("wr_p1", instr_pc, 32'h0);

        // Asynchronous reset mid-stream
        #2 rst_n = 0;
        #1 chk_reset_vals("arst");
        @(negedge clk);
        rst_n = 1;
        cyc();
        cmp_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
